// File: rtl/instr_fetch_queue_if.sv
// Shared fetch-entry types and the fetch/decode handshake bundle of the instruction fetch queue.
package tortoise_pkg;
  localparam int unsigned IFQ_DEPTH       = 8;
  localparam int unsigned INSTR_PER_FETCH = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] cause;
    logic [31:0] tval;
  } exception_t;

  typedef struct packed {
    logic        is_taken;
    logic [31:0] predict_address;
  } branchpredict_t;

  typedef struct packed {
    logic           valid;
    logic [31:0]    addr;
    logic [31:0]    instr;
    exception_t     ex;
    branchpredict_t predict;
  } fetch_entry_t;
endpackage

interface instr_fetch_queue_if #(
  parameter int unsigned DEPTH    = tortoise_pkg::IFQ_DEPTH,
  parameter int unsigned NR_LANES = tortoise_pkg::INSTR_PER_FETCH
);
  import tortoise_pkg::*;

  logic                              flush_i;
  fetch_entry_t [NR_LANES-1:0]       fetch_entries_i;
  logic                              fetch_ready_o;
  fetch_entry_t                      decode_entry_o;
  logic                              decode_valid_o;
  logic                              decode_ready_i;
  logic [$clog2(DEPTH):0]            count_o;

  modport master (
    output flush_i, fetch_entries_i, decode_ready_i,
    input  fetch_ready_o, decode_entry_o, decode_valid_o, count_o
  );

  modport slave (
    input  flush_i, fetch_entries_i, decode_ready_i,
    output fetch_ready_o, decode_entry_o, decode_valid_o, count_o
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch-to-decode queue: filters wrong-path lanes, compacts survivors into a circular buffer.
// Latency: 1 cycle push-to-head, no bypass. Flush empties the queue on the next edge.
// Backpressure: a whole group is refused unless NR_LANES slots are free (registered count only).
module instr_fetch_queue
  import tortoise_pkg::*;
#(
  parameter int unsigned DEPTH    = IFQ_DEPTH,
  parameter int unsigned NR_LANES = INSTR_PER_FETCH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  instr_fetch_queue_if.slave ifq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] ROOM_LIMIT = CNT_W'(DEPTH - NR_LANES);

  fetch_entry_t         mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic [NR_LANES-1:0]  keep;
  logic [PTR_W-1:0]     slot_off [NR_LANES];
  logic [CNT_W-1:0]     kept_cnt;
  logic                 push;
  logic                 pop;

  // A taken or faulting lane is kept but closes the group for every younger lane.
  always_comb begin
    logic stop;
    stop     = 1'b0;
    kept_cnt = '0;
    keep     = '0;
    slot_off = '{default: '0};
    for (int i = 0; i < NR_LANES; i++) begin
      slot_off[i] = kept_cnt[PTR_W-1:0];
      keep[i]     = ifq.fetch_entries_i[i].valid && !stop;
      if (keep[i]) begin
        kept_cnt = kept_cnt + CNT_W'(1);
        if (ifq.fetch_entries_i[i].predict.is_taken || ifq.fetch_entries_i[i].ex.valid) begin
          stop = 1'b1;
        end
      end
    end
  end

  assign ifq.fetch_ready_o  = !ifq.flush_i && (count <= ROOM_LIMIT);
  assign ifq.decode_valid_o = (count != '0) && !ifq.flush_i;
  assign ifq.decode_entry_o = mem[rd_ptr];
  assign ifq.count_o        = count;

  assign push = ifq.fetch_ready_o && (kept_cnt != '0);
  assign pop  = ifq.decode_valid_o && ifq.decode_ready_i;

  always_comb begin
    count_next = count;
    if (push) begin
      count_next = count_next + kept_cnt;
    end
    if (pop) begin
      count_next = count_next - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (ifq.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + kept_cnt[PTR_W-1:0];
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
    end
  end

  // Storage is deliberately left out of reset; only pointers and count define occupancy.
  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int i = 0; i < NR_LANES; i++) begin
        if (keep[i]) begin
          mem[wr_ptr + slot_off[i]] <= ifq.fetch_entries_i[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed scoreboard bench for instr_fetch_queue with DEPTH=8, NR_LANES=2.
module tb_instr_fetch_queue;
  import tortoise_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_queue_if #(.DEPTH(DEPTH), .NR_LANES(2)) ifq ();

  instr_fetch_queue #(.DEPTH(DEPTH), .NR_LANES(2)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .ifq   (ifq)
  );

  int checks = 0;
  int errors = 0;
  int mcount = 0;
  fetch_entry_t expq[$];
  fetch_entry_t nul;

  function automatic fetch_entry_t mk(input logic [31:0] a, input logic v, input logic t,
                                      input logic x);
    fetch_entry_t e;
    e.valid                   = v;
    e.addr                    = a;
    e.instr                   = a ^ 32'h1357_9bdf;
    e.ex.valid                = x;
    e.ex.cause                = x ? 32'd1 : 32'd0;
    e.ex.tval                 = a;
    e.predict.is_taken        = t;
    e.predict.predict_address = a + 32'h40;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every handshake must deliver the oldest outstanding expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count_bound", 32'(ifq.count_o <= 4'(DEPTH)), 32'd1);
      if (ifq.decode_valid_o && ifq.decode_ready_i) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL decode_unexpected actual addr=%h required none", ifq.decode_entry_o.addr);
        end else begin
          fetch_entry_t e;
          e = expq.pop_front();
          if (ifq.decode_entry_o !== e) begin
            errors++;
            $display("FAIL decode_entry actual addr=%h instr=%h required addr=%h instr=%h",
                     ifq.decode_entry_o.addr, ifq.decode_entry_o.instr, e.addr, e.instr);
          end
        end
      end
    end
  end

  // One cycle of stimulus; keep is the hand-derived set of surviving lanes.
  task automatic run_cycle(input fetch_entry_t l0, input fetch_entry_t l1, input logic [1:0] keep,
                           input logic rdy, input logic flush);
    logic exp_rdy, exp_vld;
    @(posedge clk); #1;
    ifq.fetch_entries_i[0] = l0;
    ifq.fetch_entries_i[1] = l1;
    ifq.decode_ready_i     = rdy;
    ifq.flush_i            = flush;
    @(negedge clk);
    exp_rdy = !flush && (DEPTH - mcount >= 2);
    exp_vld = (mcount != 0) && !flush;
    chk("fetch_ready", 32'(ifq.fetch_ready_o), 32'(exp_rdy));
    chk("decode_valid", 32'(ifq.decode_valid_o), 32'(exp_vld));
    chk("count", 32'(ifq.count_o), 32'(mcount));
    if (flush) begin
      mcount = 0;
      expq.delete();
    end else begin
      if (exp_rdy && keep != 2'b00) begin
        if (keep[0]) expq.push_back(l0);
        if (keep[1]) expq.push_back(l1);
        mcount += int'(keep[0]) + int'(keep[1]);
      end
      if (exp_vld && rdy) mcount--;
    end
  endtask

  task automatic idle(input logic rdy);
    run_cycle(nul, nul, 2'b00, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && mcount != 0; i++) idle(1'b1);
    chk("drained", 32'(mcount), 32'd0);
  endtask

  initial begin
    nul = mk(32'h0, 1'b0, 1'b0, 1'b0);
    ifq.flush_i            = 1'b0;
    ifq.decode_ready_i     = 1'b0;
    ifq.fetch_entries_i[0] = nul;
    ifq.fetch_entries_i[1] = nul;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_count", 32'(ifq.count_o), 32'd0);
    chk("reset_valid", 32'(ifq.decode_valid_o), 32'd0);
    chk("reset_ready", 32'(ifq.fetch_ready_o), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Two-lane group, then in-order delivery.
    run_cycle(mk(32'h8000_0000, 1, 0, 0), mk(32'h8000_0004, 1, 0, 0), 2'b11, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Taken lane 0 drops lane 1.
    run_cycle(mk(32'h100, 1, 1, 0), mk(32'h104, 1, 0, 0), 2'b01, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Compaction with empty queue and decode ready in the push cycle.
    run_cycle(mk(32'h200, 0, 0, 0), mk(32'h204, 1, 0, 0), 2'b10, 1'b1, 1'b0);
    idle(1'b1);
    // Faulting lane 0 drops lane 1; taken lane 1 is itself kept.
    run_cycle(mk(32'h300, 1, 0, 1), mk(32'h304, 1, 0, 0), 2'b01, 1'b0, 1'b0);
    run_cycle(mk(32'h400, 1, 0, 0), mk(32'h404, 1, 1, 0), 2'b11, 1'b0, 1'b0);
    drain();

    // Fill to 8, pop to 7: groups refused at both.
    for (int k = 0; k < 4; k++)
      run_cycle(mk(32'h1000 + 32'(8 * k), 1, 0, 0), mk(32'h1004 + 32'(8 * k), 1, 0, 0),
                2'b11, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    run_cycle(mk(32'h1f00, 1, 0, 0), mk(32'h1f04, 1, 0, 0), 2'b11, 1'b0, 1'b0);

    // Continuous push/pop across pointer wrap.
    for (int k = 0; k < 20; k++)
      run_cycle(mk(32'h2000 + 32'(8 * k), 1, 0, 0), mk(32'h2004 + 32'(8 * k), 1, 0, 0),
                2'b11, 1'b1, 1'b0);
    drain();

    // Count 5, then flush together with push and pop.
    run_cycle(mk(32'h3000, 1, 0, 0), mk(32'h3004, 1, 0, 0), 2'b11, 1'b0, 1'b0);
    run_cycle(mk(32'h3008, 1, 0, 0), mk(32'h300c, 1, 0, 0), 2'b11, 1'b0, 1'b0);
    run_cycle(mk(32'h3010, 1, 0, 0), mk(32'h3014, 0, 0, 0), 2'b01, 1'b0, 1'b0);
    idle(1'b0);
    run_cycle(mk(32'h3100, 1, 0, 0), mk(32'h3104, 1, 0, 0), 2'b11, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b0);

    // Count 3, then asynchronous reset between edges.
    run_cycle(mk(32'h4000, 1, 0, 0), mk(32'h4004, 1, 0, 0), 2'b11, 1'b0, 1'b0);
    run_cycle(mk(32'h4008, 1, 0, 0), mk(32'h400c, 0, 0, 0), 2'b01, 1'b0, 1'b0);
    idle(1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(ifq.count_o), 32'd0);
    chk("async_rst_valid", 32'(ifq.decode_valid_o), 32'd0);
    chk("async_rst_ready", 32'(ifq.fetch_ready_o), 32'd1);
    mcount = 0;
    expq.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Queue restarts cleanly after reset.
    run_cycle(mk(32'h5000, 1, 0, 0), mk(32'h5004, 1, 0, 0), 2'b11, 1'b0, 1'b0);
    drain();
    idle(1'b0);

    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch queue between the fetch stage and the decoder. Accepts a group of up to INSTR_PER_FETCH fetch_entry_t lanes per cycle, drops wrong-path lanes behind a predicted-taken branch or a faulting lane, and stores the survivors in a circular buffer of IFQ_DEPTH entries. Presents the oldest entry to decode with a valid/ready handshake. Supports a single-cycle flush on pipeline redirect.

## Interface

Parameters:
- DEPTH, default tortoise_pkg::IFQ_DEPTH, queue capacity; power of two, >= NR_LANES.
- NR_LANES, default tortoise_pkg::INSTR_PER_FETCH, fetch group width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- flush_i  input  1  discard all queued entries and the incoming group.
- fetch_entries_i  input  fetch_entry_t[NR_LANES]  fetch group; lane 0 is the oldest; per-lane .valid.
- fetch_ready_o  output  1  group accepted this cycle if any lane is valid.
- decode_entry_o  output  fetch_entry_t  head entry; don't-care when decode_valid_o=0.
- decode_valid_o  output  1  head entry present.
- decode_ready_i  input  1  decoder consumes the head entry.
- count_o  output  $clog2(DEPTH)+1  number of stored entries (registered).

## Operation

- Storage: array of DEPTH fetch_entry_t; read pointer and write pointer, each $clog2(DEPTH) bits, wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Lane filtering applies within a group only. A lane is kept iff its .valid=1 and no lower-numbered kept lane has predict.is_taken=1 or ex.valid=1. The taken or faulting lane itself is kept. Later lanes are dropped silently.
- Compaction: kept lanes are written to consecutive slots starting at the write pointer, in lane order. Gaps from invalid lanes are squeezed out. The write pointer advances by the kept count (0..NR_LANES).
- Push occurs iff fetch_ready_o=1, flush_i=0, and kept count > 0. The group is all-or-nothing; no partial acceptance.
- fetch_ready_o = !flush_i && (DEPTH - count >= NR_LANES). Computed from the registered count only; a same-cycle pop does not raise it.
- Pop occurs iff decode_valid_o=1 and decode_ready_i=1. The read pointer advances by 1.
- decode_valid_o = (count != 0) && !flush_i.
- decode_entry_o = array[read pointer]. Combinational from storage; no bypass from input to output.
- Count update when push and pop happen in the same cycle: count_next = count + kept - popped.
- Flush has priority over push and pop. On the next edge, pointers = 0 and count = 0. Storage contents are not cleared.
- Entries pass through unmodified: ex, predict, addr and instr are copied bit-exact.
- No state machine beyond the pointers and count. Overflow is impossible by construction; the bench asserts count <= DEPTH.

## Timing

- Reset (rst_ni=0, asynchronous): read pointer = 0, write pointer = 0, count = 0. Outputs: count_o=0, decode_valid_o=0, fetch_ready_o=1 (when flush_i=0). Storage is not reset.
- Reset deasserted mid-operation: the queue restarts empty; nothing survives reset.
- Latency: an entry pushed at edge N appears on decode_entry_o with decode_valid_o=1 in the cycle after edge N. There is no same-cycle passthrough; minimum fetch-to-decode is 1 cycle.
- Throughput: NR_LANES entries in, 1 entry out per cycle.
- Full: count > DEPTH-NR_LANES forces fetch_ready_o=0, even if a pop occurs that cycle.
- Empty with push and decode_ready_i=1 in the same cycle: no pop; decode_valid_o=0 that cycle.
- Flush asserted together with push and pop: neither takes effect; the queue is empty after the edge.

## Test plan

- Reset, then group {valid,valid} at addr 0x80000000/0x80000004, decode_ready_i=0 → count_o=2 next cycle; head addr 0x80000000. Pop twice → addrs in order, then decode_valid_o=0.
- NR_LANES=2, lane0 predict.is_taken=1 (addr 0x100), lane1 valid (0x104) → count_o=1; only 0x100 is delivered.
- Lane0 .valid=0, lane1 valid (0x204) → stored at slot 0 (compaction); head addr 0x204.
- DEPTH=8, NR_LANES=2: push full groups with decode_ready_i=0 → count 8, fetch_ready_o=0 at count 7 and 8. Then pop and push continuously for 20 cycles → addresses stay strictly in order across pointer wrap.
- Count=5 with flush_i=1, a valid group, and decode_ready_i=1 → count_o=0 next cycle, decode_valid_o=0 during the flush cycle, no entry delivered.
- Assert rst_ni low asynchronously between edges with count=3 → count_o=0 and decode_valid_o=0 immediately, before the next edge.
